// File: rtl/itch_pkg.sv
// Shared types and constants for the ITCH/MoldUDP64 transmit frame builder.
// The header record is laid out in wire order: byte 0 occupies the top bits.
package itch_pkg;

  localparam int          HDR_BEATS  = 8;
  localparam logic [15:0] ETYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  PROTO_UDP  = 8'h11;

  typedef enum logic [1:0] {IDLE, CSUM, HDR, PAYLOAD} state_t;

  typedef struct packed {
    logic [47:0] dMac;
    logic [47:0] sMac;
    logic [15:0] oTag;
    logic [15:0] eType;
    logic [3:0]  version;
    logic [3:0]  headerLength;
    logic [7:0]  tos;
    logic [15:0] totalLength;
    logic [15:0] id;
    logic [2:0]  flags;
    logic [12:0] fragOffset;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] hdrChecksum;
    logic [31:0] srcIP;
    logic [31:0] dstIP;
    logic [15:0] srcPort;
    logic [15:0] dstPort;
    logic [15:0] udpLength;
    logic [15:0] udpChecksum;
    logic [79:0] sessionID;
    logic [63:0] sequenceNumber;
    logic [15:0] messageCount;
  } mold_hdr_t;

  function automatic logic [6:0] sat_inc(input logic [6:0] v);
    return (v == 7'd127) ? v : v + 7'd1;
  endfunction

endpackage

// File: rtl/ipv4_hdr_csum.sv
// Combinational IPv4 header checksum over the 20-byte header.
// The checksum word (word 5) is treated as zero while summing.
module ipv4_hdr_csum (
  input  logic [159:0] hdr,
  output logic [15:0]  csum
);

  logic [19:0] sum;
  logic [16:0] fold1;
  logic [15:0] fold2;

  // NOTE: blocking assignments are correct inside always_comb; the loop
  // accumulates into sum within a single evaluation.
  always_comb begin
    sum = '0;
    for (int i = 0; i < 10; i++) begin
      if (i != 5) sum = sum + 20'(hdr[159-16*i -: 16]);
    end
    // Two end-around folds: the first carry can be up to 4 bits, the
    // second is at most one bit and cannot overflow again.
    fold1 = 17'(sum[15:0]) + 17'(sum[19:16]);
    fold2 = fold1[15:0] + 16'(fold1[16]);
    csum  = ~fold2;
  end

endmodule

// File: rtl/itch_tx_frame_builder.sv
// Serialises a MoldUDP64 header record into 8 x 64-bit beats, then passes
// the ITCH payload straight through on the same stream.
module itch_tx_frame_builder
  import itch_pkg::*;
#(
  parameter bit CSUM_EN   = 1'b1,
  parameter int HDR_BEATS = itch_pkg::HDR_BEATS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] hdr_in,
  input  logic         hdr_valid,
  output logic         hdr_ready,
  input  logic [63:0]  pl_data,
  input  logic [7:0]   pl_keep,
  input  logic         pl_last,
  input  logic         pl_valid,
  output logic         pl_ready,
  output logic [63:0]  tx_data_net,
  output logic [7:0]   tx_keep,
  output logic         tx_last,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [6:0]   beat_cnt
);

  state_t    state, state_nxt;
  mold_hdr_t hdr_reg;
  logic [HDR_BEATS-1:0][63:0] hdr_words;
  logic [2:0]  k;
  logic [15:0] csum;
  logic        hdr_accept;
  logic        tx_accept;
  logic        last_hdr_beat;
  logic        heartbeat;

  assign hdr_words     = hdr_reg;
  assign k             = beat_cnt[2:0];
  assign hdr_accept    = hdr_valid & hdr_ready;
  assign tx_accept     = tx_valid & tx_ready;
  assign last_hdr_beat = (k == 3'(HDR_BEATS - 1));
  assign heartbeat     = (hdr_reg.messageCount == 16'd0);

  // IPv4 header spans version .. dstIP, bytes 16..35 of the record.
  ipv4_hdr_csum u_csum (
    .hdr  (hdr_reg[383:224]),
    .csum (csum)
  );

  always_comb begin
    state_nxt   = state;
    hdr_ready   = 1'b0;
    pl_ready    = 1'b0;
    tx_valid    = 1'b0;
    tx_keep     = 8'h00;
    tx_last     = 1'b0;
    tx_data_net = 64'd0;
    case (state)
      IDLE: begin
        // Held low while rst is high so it only rises once reset releases.
        hdr_ready = ~rst;
        if (hdr_valid & ~rst) state_nxt = CSUM;
      end
      CSUM: state_nxt = HDR;
      HDR: begin
        tx_valid    = 1'b1;
        tx_keep     = 8'hFF;
        tx_data_net = hdr_words[3'(HDR_BEATS - 1) - k];
        tx_last     = last_hdr_beat & heartbeat;
        if (tx_ready & last_hdr_beat) state_nxt = heartbeat ? IDLE : PAYLOAD;
      end
      PAYLOAD: begin
        tx_valid    = pl_valid;
        tx_data_net = pl_data;
        tx_keep     = pl_keep;
        tx_last     = pl_last;
        pl_ready    = tx_ready;
        if (pl_valid & tx_ready & pl_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= 7'd0;
    end else begin
      state <= state_nxt;
      if (hdr_accept)     beat_cnt <= 7'd0;
      else if (tx_accept) beat_cnt <= sat_inc(beat_cnt);
    end
  end

  // NOTE: the header register is pure datapath, always loaded before use,
  // so it carries no reset.
  always_ff @(posedge clk) begin
    if (hdr_accept)                  hdr_reg             <= hdr_in;
    else if (CSUM_EN && state == CSUM) hdr_reg.hdrChecksum <= csum;
  end

endmodule

// File: tb/tb_itch_tx_frame_builder.sv
// Self-checking bench for itch_tx_frame_builder: byte-level frame model,
// per-cycle compare process and directed frame scenarios.
module tb_itch_tx_frame_builder;
  import itch_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [511:0] hdr_in = '0;
  logic         hdr_valid = 1'b0;
  logic         hdr_ready;
  logic [63:0]  pl_data = '0;
  logic [7:0]   pl_keep = '0;
  logic         pl_last = 1'b0;
  logic         pl_valid = 1'b0;
  logic         pl_ready;
  logic [63:0]  tx_data_net;
  logic [7:0]   tx_keep;
  logic         tx_last;
  logic         tx_valid;
  logic         tx_ready = 1'b1;
  logic [6:0]   beat_cnt;

  always #5 clk = ~clk;

  itch_tx_frame_builder #(.CSUM_EN(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .hdr_in      (hdr_in),
    .hdr_valid   (hdr_valid),
    .hdr_ready   (hdr_ready),
    .pl_data     (pl_data),
    .pl_keep     (pl_keep),
    .pl_last     (pl_last),
    .pl_valid    (pl_valid),
    .pl_ready    (pl_ready),
    .tx_data_net (tx_data_net),
    .tx_keep     (tx_keep),
    .tx_last     (tx_last),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .beat_cnt    (beat_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_wide(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    int          idx;
    bit          is_pl;
  } exp_t;

  exp_t        expq[$];
  logic [63:0] pl_d [32];
  logic [7:0]  pl_k [32];

  function automatic logic [7:0] byte_of(input logic [511:0] h, input int i);
    return h[511-8*i -: 8];
  endfunction

  // IPv4 header lives at bytes 16..35; its checksum at bytes 26..27.
  function automatic logic [15:0] model_csum(input logic [511:0] h);
    int unsigned s = 0;
    for (int i = 0; i < 10; i++) begin
      if (i != 5) s += 32'({byte_of(h, 16 + 2*i), byte_of(h, 17 + 2*i)});
    end
    while (s > 32'h0000_FFFF) s = (s & 32'h0000_FFFF) + (s >> 16);
    return ~s[15:0];
  endfunction

  function automatic logic [511:0] model_hdr(input logic [511:0] h);
    logic [511:0] r = h;
    r[511-8*26 -: 16] = model_csum(h);
    return r;
  endfunction

  task automatic push_frame(input logic [511:0] h, input int n_pl);
    logic [511:0] eh = model_hdr(h);
    logic [15:0]  mc = {byte_of(eh, 62), byte_of(eh, 63)};
    exp_t e;
    for (int b = 0; b < 8; b++) begin
      e.data = eh[511-64*b -: 64];
      e.keep = 8'hFF;
      e.last = (b == 7) && (mc == 16'd0);
      e.idx = b;
      e.is_pl = 1'b0;
      expq.push_back(e);
    end
    for (int j = 0; j < n_pl; j++) begin
      e.data = pl_d[j];
      e.keep = pl_k[j];
      e.last = (j == n_pl - 1);
      e.idx = 8 + j;
      e.is_pl = 1'b1;
      expq.push_back(e);
    end
  endtask

  // ---------------- compare process ----------------
  logic [63:0] cap_data [32];
  logic [7:0]  cap_keep [32];
  logic        cap_last [32];
  int          cap_n = 0;
  bit          held_v = 1'b0;
  exp_t        held;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held_v = 1'b0;
    end else if (tx_valid) begin
      if (held_v) begin
        check("stall_data", tx_data_net, held.data);
        check("stall_keep", 64'(tx_keep), 64'(held.keep));
        check("stall_last", 64'(tx_last), 64'(held.last));
      end
      check("hdr_ready_busy", 64'(hdr_ready), 64'd0);
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data %h with no beat expected", tx_data_net);
      end else begin
        e = expq[0];
        if (e.is_pl) check("pl_ready_tracks", 64'(pl_ready), 64'(tx_ready));
        else         check("pl_ready_hdr", 64'(pl_ready), 64'd0);
        if (tx_ready) begin
          e = expq.pop_front();
          check($sformatf("beat%0d_data", e.idx), tx_data_net, e.data);
          check($sformatf("beat%0d_keep", e.idx), 64'(tx_keep), 64'(e.keep));
          check($sformatf("beat%0d_last", e.idx), 64'(tx_last), 64'(e.last));
          check($sformatf("beat%0d_cnt", e.idx), 64'(beat_cnt), 64'((e.idx > 127) ? 127 : e.idx));
          if (cap_n < 32) begin
            cap_data[cap_n] = tx_data_net;
            cap_keep[cap_n] = tx_keep;
            cap_last[cap_n] = tx_last;
          end
          cap_n++;
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held.data = tx_data_net;
          held.keep = tx_keep;
          held.last = tx_last;
        end
      end
    end
  end

  // ---------------- tx_ready driver ----------------
  bit rand_mode = 1'b0;
  always begin
    @(posedge clk);
    #1;
    tx_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- stimulus tasks ----------------
  task automatic offer_header(input logic [511:0] h, input int n_pl, input bit chk_lat);
    int n = 0;
    bit ok = 1'b0;
    @(posedge clk);
    #1;
    hdr_in = h;
    hdr_valid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (hdr_ready) ok = 1'b1;
      n++;
    end
    if (!ok) begin
      fail_now("hdr_accept_timeout");
      hdr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    hdr_valid = 1'b0;
    push_frame(h, n_pl);
    if (chk_lat) begin
      @(negedge clk);
      check("latency_n1_idle", 64'(tx_valid), 64'd0);
      @(negedge clk);
      check("latency_n2_valid", 64'(tx_valid), 64'd1);
    end
  endtask

  task automatic drive_payload(input int n_pl);
    @(posedge clk);
    #1;
    for (int j = 0; j < n_pl; j++) begin
      int n = 0;
      bit ok = 1'b0;
      pl_valid = 1'b1;
      pl_data = pl_d[j];
      pl_keep = pl_k[j];
      pl_last = (j == n_pl - 1);
      while (!ok && n < 200) begin
        @(negedge clk);
        if (pl_ready) ok = 1'b1;
        n++;
      end
      if (!ok) begin
        fail_now("pl_accept_timeout");
        break;
      end
      @(posedge clk);
      #1;
    end
    pl_valid = 1'b0;
    pl_last = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (expq.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (expq.size() != 0) begin
      fail_now("drain_timeout");
      expq.delete();
    end
    @(posedge clk);
  endtask

  task automatic run_frame(input logic [511:0] h, input int n_pl);
    cap_n = 0;
    offer_header(h, n_pl, 1'b0);
    if (n_pl > 0) drive_payload(n_pl);
    wait_drain();
  endtask

  function automatic int count_last(input int n);
    int c = 0;
    for (int i = 0; i < n && i < 32; i++) if (cap_last[i]) c++;
    return c;
  endfunction

  // ---------------- directed scenarios ----------------
  mold_hdr_t    hb;
  logic [511:0] hr;
  logic [511:0] rx;

  initial begin
    hb = '0;
    hb.dMac = 48'h0100_5E00_0001;
    hb.sMac = 48'h0200_1122_3344;
    hb.oTag = 16'h8100;
    hb.eType = ETYPE_IPV4;
    hb.version = 4'h4;
    hb.headerLength = 4'h5;
    hb.tos = 8'h00;
    hb.totalLength = 16'h0073;
    hb.id = 16'h0000;
    hb.flags = 3'b010;
    hb.fragOffset = 13'd0;
    hb.ttl = 8'h40;
    hb.protocol = PROTO_UDP;
    hb.hdrChecksum = 16'hDEAD;
    hb.srcIP = 32'hC0A8_0001;
    hb.dstIP = 32'hC0A8_00C7;
    hb.srcPort = 16'h1234;
    hb.dstPort = 16'h5678;
    hb.udpLength = 16'h005F;
    hb.udpChecksum = 16'h0000;
    hb.sessionID = 80'h4142_4344_4546_4748_494A;
    hb.sequenceNumber = 64'h0000_0000_0000_0100;
    hb.messageCount = 16'd0;

    // Reset state.
    #2;
    check("rst_hdr_ready", 64'(hdr_ready), 64'd0);
    check("rst_pl_ready", 64'(pl_ready), 64'd0);
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_last", 64'(tx_last), 64'd0);
    check("rst_tx_keep", 64'(tx_keep), 64'd0);
    check("rst_tx_data", tx_data_net, 64'd0);
    check("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("hdr_ready_after_rst", 64'(hdr_ready), 64'd1);

    check("model_csum_literal", 64'(model_csum(hb)), 64'h0000_0000_0000_B861);

    // Heartbeat: 8 beats, tx_last only on the 8th, hdr_ready one cycle later.
    begin
      int n = 0;
      bit seen = 1'b0;
      cap_n = 0;
      offer_header(hb, 0, 1'b1);
      while (!seen && n < 100) begin
        @(negedge clk);
        if (tx_valid && tx_ready && tx_last) seen = 1'b1;
        n++;
      end
      if (!seen) fail_now("hb_last_timeout");
      @(posedge clk);
      #1;
      check("hb_hdr_ready_next", 64'(hdr_ready), 64'd1);
      check("hb_beat_cnt", 64'(beat_cnt), 64'd8);
      check("hb_beats", 64'(cap_n), 64'd8);
      check("hb_last_count", 64'(count_last(cap_n)), 64'd1);
      check("hb_last_on_8", 64'(cap_last[7]), 64'd1);
      check("hb_csum_beat3", 64'(cap_data[3][47:32]), 64'h0000_0000_0000_B861);
      check("hb_beat0", cap_data[0], 64'h0100_5E00_0001_0200);
    end

    // One message, 3 payload beats, last partial.
    hb.messageCount = 16'd1;
    pl_d[0] = 64'h0011_2233_4455_6677; pl_k[0] = 8'hFF;
    pl_d[1] = 64'h8899_AABB_CCDD_EEFF; pl_k[1] = 8'hFF;
    pl_d[2] = 64'hCAFE_F00D_0000_0000; pl_k[2] = 8'hF0;
    run_frame(hb, 3);
    check("pl_beats", 64'(cap_n), 64'd11);
    check("pl_last_count", 64'(count_last(cap_n)), 64'd1);
    check("pl_last_on_11", 64'(cap_last[10]), 64'd1);
    check("pl_keep_last", 64'(cap_keep[10]), 64'h0000_0000_0000_00F0);
    check("pl_beat9", cap_data[9], 64'h8899_AABB_CCDD_EEFF);

    // Random back-pressure through header and payload.
    rand_mode = 1'b1;
    hb.messageCount = 16'd3;
    for (int j = 0; j < 5; j++) begin
      pl_d[j] = {$urandom(), $urandom()};
      pl_k[j] = (j == 4) ? 8'hC0 : 8'hFF;
    end
    run_frame(hb, 5);
    check("bp_beats", 64'(cap_n), 64'd13);
    hb.messageCount = 16'd0;
    run_frame(hb, 0);
    check("bp_hb_beats", 64'(cap_n), 64'd8);
    rand_mode = 1'b0;
    repeat (2) @(posedge clk);

    // Reset while beat 4 is on the bus.
    begin
      int n = 0;
      cap_n = 0;
      offer_header(hb, 0, 1'b0);
      while (cap_n < 4 && n < 100) begin
        @(posedge clk);
        n++;
      end
      if (cap_n < 4) fail_now("rst_mid_wait");
      #2;
      rst = 1'b1;
      #1;
      check("rst_mid_tx_valid", 64'(tx_valid), 64'd0);
      check("rst_mid_tx_data", tx_data_net, 64'd0);
      check("rst_mid_hdr_ready", 64'(hdr_ready), 64'd0);
      check("rst_mid_beat_cnt", 64'(beat_cnt), 64'd0);
      expq.delete();
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("rst_mid_idle", 64'(hdr_ready), 64'd1);
      run_frame(hb, 0);
      check("post_rst_beats", 64'(cap_n), 64'd8);
      check("post_rst_last8", 64'(cap_last[7]), 64'd1);
    end

    // Loopback: reassemble a random record from the wire and compare.
    for (int i = 0; i < 16; i++) hr[32*i +: 32] = $urandom();
    hr[15:0] = 16'd2;
    pl_d[0] = 64'h1111_2222_3333_4444; pl_k[0] = 8'hFF;
    pl_d[1] = 64'h5555_6666_7777_8888; pl_k[1] = 8'hFC;
    rand_mode = 1'b1;
    run_frame(hr, 2);
    rand_mode = 1'b0;
    rx = {cap_data[0], cap_data[1], cap_data[2], cap_data[3],
          cap_data[4], cap_data[5], cap_data[6], cap_data[7]};
    check_wide("loop_record", rx, model_hdr(hr));
    check("loop_csum", 64'(rx[303:288]), 64'(model_csum(hr)));
    check("loop_seq", rx[79:16], hr[79:16]);
    check("loop_beats", 64'(cap_n), 64'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
